// File: rtl/nibble_io_port.sv
// Board-side peer of the Datapath 4-bit I/O: ingress FIFO (host -> dp_in) and egress FIFO (dp_out -> host).
// Optional egress drop counter enabled by defining NIBBLE_IO_DROP_CNT_EN.

module nibble_io_fifo #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] EMPTY_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [3:0] i_wdata,
  output logic [3:0] o_rdata,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  // Flags come only from the registered count, so requests never reach ready/valid combinationally.
  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage carries data only; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = o_empty ? EMPTY_VAL : r_mem[r_rd_ptr];
endmodule

module nibble_io_port #(
  parameter int         DEPTH     = 4,
  parameter logic [3:0] EMPTY_VAL = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] host_tx_data,
  input  logic       host_tx_valid,
  output logic       host_tx_ready,
  output logic [3:0] dp_in,
  output logic       dp_in_valid,
  input  logic       dp_in_rd,
  input  logic [3:0] dp_out,
  input  logic       dp_out_wr,
  output logic       dp_out_full,
  output logic [3:0] host_rx_data,
  output logic       host_rx_valid,
  input  logic       host_rx_ready,
  output logic [7:0] drop_cnt
);
  logic w_in_full;
  logic w_in_empty;
  logic w_eg_full;
  logic w_eg_empty;

  nibble_io_fifo #(.DEPTH(DEPTH), .EMPTY_VAL(EMPTY_VAL)) u_ingress (
    .clk     (clk),
    .rst     (rst),
    .i_push  (host_tx_valid),
    .i_pop   (dp_in_rd),
    .i_wdata (host_tx_data),
    .o_rdata (dp_in),
    .o_full  (w_in_full),
    .o_empty (w_in_empty)
  );

  nibble_io_fifo #(.DEPTH(DEPTH), .EMPTY_VAL(4'h0)) u_egress (
    .clk     (clk),
    .rst     (rst),
    .i_push  (dp_out_wr),
    .i_pop   (host_rx_ready),
    .i_wdata (dp_out),
    .o_rdata (host_rx_data),
    .o_full  (w_eg_full),
    .o_empty (w_eg_empty)
  );

  assign host_tx_ready = !w_in_full;
  assign dp_in_valid   = !w_in_empty;
  assign dp_out_full   = w_eg_full;
  assign host_rx_valid = !w_eg_empty;

`ifdef NIBBLE_IO_DROP_CNT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] r_drop_cnt;

  // A write strobe against a full egress FIFO is a drop, judged on the pre-edge full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'h00;
    end else if (dp_out_wr && w_eg_full) begin
      r_drop_cnt <= sat_inc8(r_drop_cnt);
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_nibble_io_port.sv
// Bench for nibble_io_port: queue-based reference model checked every cycle plus directed literal checks.
// Drop-count expectations follow NIBBLE_IO_DROP_CNT_EN when it is defined for the build.

module tb_nibble_io_port;
  localparam int DEPTH = 4;

  logic       clk = 1'b1;
  logic       rst = 1'b1;
  logic [3:0] host_tx_data = 4'h0;
  logic       host_tx_valid = 1'b0;
  logic       host_tx_ready;
  logic [3:0] dp_in;
  logic       dp_in_valid;
  logic       dp_in_rd = 1'b0;
  logic [3:0] dp_out = 4'h0;
  logic       dp_out_wr = 1'b0;
  logic       dp_out_full;
  logic [3:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready = 1'b0;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] in_q[$];
  logic [3:0] eg_q[$];
  int         m_drop = 0;

  nibble_io_port #(.DEPTH(DEPTH), .EMPTY_VAL(4'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .dp_in         (dp_in),
    .dp_in_valid   (dp_in_valid),
    .dp_in_rd      (dp_in_rd),
    .dp_out        (dp_out),
    .dp_out_wr     (dp_out_wr),
    .dp_out_full   (dp_out_full),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .drop_cnt      (drop_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: two queues, decisions taken from occupancy before the edge.
  task automatic model_step();
    bit ipush, ipop, epush, epop;
    if (rst) begin
      in_q.delete();
      eg_q.delete();
      m_drop = 0;
      return;
    end
    ipush = host_tx_valid && (in_q.size() < DEPTH);
    ipop  = dp_in_rd && (in_q.size() > 0);
    epush = dp_out_wr && (eg_q.size() < DEPTH);
    epop  = host_rx_ready && (eg_q.size() > 0);
`ifdef NIBBLE_IO_DROP_CNT_EN
    if (dp_out_wr && (eg_q.size() == DEPTH) && (m_drop < 255)) m_drop++;
`endif
    if (ipop) void'(in_q.pop_front());
    if (ipush) in_q.push_back(host_tx_data);
    if (epop) void'(eg_q.pop_front());
    if (epush) eg_q.push_back(dp_out);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic check_all();
    chk("host_tx_ready", 8'(host_tx_ready), 8'(in_q.size() < DEPTH));
    chk("dp_in_valid",   8'(dp_in_valid),   8'(in_q.size() > 0));
    chk("dp_in",         8'(dp_in),         8'((in_q.size() > 0) ? in_q[0] : 4'h0));
    chk("dp_out_full",   8'(dp_out_full),   8'(eg_q.size() == DEPTH));
    chk("host_rx_valid", 8'(host_rx_valid), 8'(eg_q.size() > 0));
    chk("host_rx_data",  8'(host_rx_data),  8'((eg_q.size() > 0) ? eg_q[0] : 4'h0));
    chk("drop_cnt",      drop_cnt,          8'(m_drop));
  endtask

  initial forever begin
    @(negedge clk);
    check_all();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset held for 15ns, released on a falling edge.
    #15 rst = 1'b0;
    #2;
    chk("rst_tx_ready", 8'(host_tx_ready), 8'h01);
    chk("rst_dp_in", 8'(dp_in), 8'h00);
    chk("rst_dp_in_valid", 8'(dp_in_valid), 8'h00);
    chk("rst_rx_valid", 8'(host_rx_valid), 8'h00);
    chk("rst_drop", drop_cnt, 8'h00);

    // Ingress fill: the fifth push meets a full FIFO and is refused.
    host_tx_valid = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      host_tx_data = 4'(v);
      tick();
    end
    host_tx_valid = 1'b0;
    chk("fill_ready", 8'(host_tx_ready), 8'h00);
    chk("fill_head", 8'(dp_in), 8'h01);

    // Push and pop together while full: only the pop happens.
    host_tx_data = 4'h6;
    host_tx_valid = 1'b1;
    dp_in_rd = 1'b1;
    tick();
    host_tx_valid = 1'b0;
    chk("in_full_simul_head", 8'(dp_in), 8'h02);
    chk("in_full_simul_ready", 8'(host_tx_ready), 8'h01);
    for (int v = 2; v <= 4; v++) begin
      chk("in_drain", 8'(dp_in), 8'(v));
      tick();
    end
    tick();
    dp_in_rd = 1'b0;
    chk("in_empty_valid", 8'(dp_in_valid), 8'h00);
    chk("in_empty_val", 8'(dp_in), 8'h00);

    // Egress drop: six writes into a four-entry FIFO with the host stalled.
    dp_out_wr = 1'b1;
    for (int v = 5; v <= 10; v++) begin
      dp_out = 4'(v);
      tick();
    end
    dp_out_wr = 1'b0;
    chk("eg_full", 8'(dp_out_full), 8'h01);
    chk("eg_head", 8'(host_rx_data), 8'h05);
`ifdef NIBBLE_IO_DROP_CNT_EN
    chk("eg_drop", drop_cnt, 8'h02);
`else
    chk("eg_drop", drop_cnt, 8'h00);
`endif
    host_rx_ready = 1'b1;
    for (int v = 5; v <= 8; v++) begin
      chk("eg_drain", 8'(host_rx_data), 8'(v));
      tick();
    end
    host_rx_ready = 1'b0;
    chk("eg_empty_valid", 8'(host_rx_valid), 8'h00);
    chk("eg_empty_data", 8'(host_rx_data), 8'h00);

    // Egress write and host read on the same edge while full.
    dp_out_wr = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      dp_out = 4'(v);
      tick();
    end
    dp_out = 4'hF;
    host_rx_ready = 1'b1;
    tick();
    dp_out_wr = 1'b0;
    chk("eg_simul_full", 8'(dp_out_full), 8'h00);
    chk("eg_simul_head", 8'(host_rx_data), 8'h02);
`ifdef NIBBLE_IO_DROP_CNT_EN
    chk("eg_simul_drop", drop_cnt, 8'h03);
`else
    chk("eg_simul_drop", drop_cnt, 8'h00);
`endif
    for (int v = 2; v <= 4; v++) begin
      chk("eg_simul_drain", 8'(host_rx_data), 8'(v));
      tick();
    end
    host_rx_ready = 1'b0;
    chk("eg_simul_lost", 8'(host_rx_valid), 8'h00);

    // Wrap: streaming 0..9 with a read beside every push keeps one entry in flight.
    host_tx_valid = 1'b1;
    dp_in_rd = 1'b1;
    for (int v = 0; v <= 9; v++) begin
      host_tx_data = 4'(v);
      if (v > 0) chk("wrap_seq", 8'(dp_in), 8'(v - 1));
      tick();
      chk("wrap_one_entry", 8'(dp_in_valid), 8'h01);
    end
    host_tx_valid = 1'b0;
    chk("wrap_last", 8'(dp_in), 8'h09);
    tick();
    dp_in_rd = 1'b0;
    chk("wrap_empty", 8'(dp_in_valid), 8'h00);

    // Mid-operation reset with three entries in each FIFO.
    host_tx_valid = 1'b1;
    dp_out_wr = 1'b1;
    for (int v = 7; v <= 9; v++) begin
      host_tx_data = 4'(v);
      dp_out = 4'(v - 6);
      tick();
    end
    host_tx_valid = 1'b0;
    dp_out_wr = 1'b0;
    chk("pre_rst_in_head", 8'(dp_in), 8'h07);
    chk("pre_rst_eg_head", 8'(host_rx_data), 8'h01);
    rst = 1'b1;
    #1;
    chk("mid_rst_tx_ready", 8'(host_tx_ready), 8'h01);
    chk("mid_rst_in_valid", 8'(dp_in_valid), 8'h00);
    chk("mid_rst_dp_in", 8'(dp_in), 8'h00);
    chk("mid_rst_rx_valid", 8'(host_rx_valid), 8'h00);
    chk("mid_rst_rx_data", 8'(host_rx_data), 8'h00);
    chk("mid_rst_full", 8'(dp_out_full), 8'h00);
    chk("mid_rst_drop", drop_cnt, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    host_tx_data = 4'hC;
    host_tx_valid = 1'b1;
    dp_out = 4'hD;
    dp_out_wr = 1'b1;
    tick();
    host_tx_valid = 1'b0;
    dp_out_wr = 1'b0;
    chk("post_rst_in", 8'(dp_in), 8'h0C);
    chk("post_rst_eg", 8'(host_rx_data), 8'h0D);
    dp_in_rd = 1'b1;
    host_rx_ready = 1'b1;
    tick();
    dp_in_rd = 1'b0;
    host_rx_ready = 1'b0;
    chk("post_rst_in_empty", 8'(dp_in_valid), 8'h00);
    chk("post_rst_eg_empty", 8'(host_rx_valid), 8'h00);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
